// File: rtl/ibex_register_file_mp.sv
// ibex_register_file_mp: multi-port flip-flop register file with bypass, collision detection and wipe engine
module ibex_register_file_mp #(
  parameter bit                   RV32E             = 1'b0,
  parameter int                   DataWidth         = 32,
  parameter int                   NumRead           = 2,
  parameter int                   NumWrite          = 2,
  parameter bit                   WriteBypass       = 1'b0,
  parameter bit                   DummyInstructions = 1'b0,
  parameter logic [DataWidth-1:0] WordZeroVal       = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          test_en_i,
  input  logic                          dummy_instr_id_i,
  input  logic                          dummy_instr_wb_i,
  input  logic [NumRead*5-1:0]          raddr_i,
  output logic [NumRead*DataWidth-1:0]  rdata_o,
  input  logic [NumWrite*5-1:0]         waddr_i,
  input  logic [NumWrite*DataWidth-1:0] wdata_i,
  input  logic [NumWrite-1:0]           we_i,
  input  logic                          wipe_req_i,
  output logic                          wipe_busy_o,
  output logic                          wipe_done_o,
  output logic                          err_o
);
  localparam int AW = RV32E ? 4 : 5;
  localparam int NW = 2 ** AW;
  typedef enum logic [1:0] {IDLE, WIPE, DONE} state_e;
  state_e               state_q;
  logic [AW-1:0]        cnt_q;
  logic                 busy_q, done_q;
  logic [DataWidth-1:0] mem_q [NW];
  logic [DataWidth-1:0] mem_d [NW];
  logic [AW-1:0]        wa [NumWrite];
  logic [AW-1:0]        ra [NumRead];
  logic                 unused_in;
  // Address bit 4 is dropped under RV32E; test enable has no function here
  assign unused_in   = ^{test_en_i, raddr_i, waddr_i};
  assign wipe_busy_o = busy_q;
  assign wipe_done_o = done_q;
  // Narrow each port address to the implemented address width
  always_comb begin
    for (int p = 0; p < NumWrite; p++) wa[p] = waddr_i[5*p +: AW];
    for (int k = 0; k < NumRead; k++) ra[k] = raddr_i[5*k +: AW];
  end
  // Collision between enabled ports on a nonzero address, or any write attempted mid-wipe
  always_comb begin
    err_o = busy_q && |we_i;
    for (int p = 0; p < NumWrite; p++)
      for (int q = p + 1; q < NumWrite; q++)
        if (we_i[p] && we_i[q] && wa[p] == wa[q] && wa[p] != '0) err_o = 1'b1;
  end
  // Next register contents: wipe owns the array while busy, else ascending ports so the highest wins
  always_comb begin
    mem_d = mem_q;
    if (busy_q) mem_d[cnt_q] = WordZeroVal;
    else begin
      for (int p = 0; p < NumWrite; p++)
        if (we_i[p] && wa[p] != '0) mem_d[wa[p]] = wdata_i[p*DataWidth +: DataWidth];
      if (DummyInstructions && we_i[0] && dummy_instr_wb_i) mem_d[0] = wdata_i[DataWidth-1:0];
    end
  end
  // Register array; entry 0 is the shadow r0 and stays at WordZeroVal without dummy instructions
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) for (int i = 0; i < NW; i++) mem_q[i] <= WordZeroVal;
    else mem_q <= mem_d;
  end
  // Combinational reads with optional same-cycle bypass, never for r0 and never while wiping
  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < NumRead; k++) begin
      rdata_o[k*DataWidth +: DataWidth] = ra[k] == '0 ?
          (DummyInstructions && dummy_instr_id_i ? mem_q[0] : WordZeroVal) : mem_q[ra[k]];
      if (WriteBypass && !busy_q && ra[k] != '0)
        for (int p = 0; p < NumWrite; p++)
          if (we_i[p] && wa[p] == ra[k]) rdata_o[k*DataWidth +: DataWidth] = wdata_i[p*DataWidth +: DataWidth];
    end
  end
  // Wipe sequencer: one register per cycle from index 0 up, then a single done pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (wipe_req_i) begin
          state_q <= WIPE;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
        end
        WIPE: begin
          cnt_q <= cnt_q + AW'(1);
          if (&cnt_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ibex_register_file_mp.sv
// tb_ibex_register_file_mp: directed checks of two register file configurations
module tb_ibex_register_file_mp;
  logic         clk = 1'b0;
  logic         rst_n, test_en;
  logic         a_did, a_dwb, a_wreq, a_busy, a_done, a_err;
  logic [9:0]   a_raddr, a_waddr;
  logic [63:0]  a_rdata, a_wdata;
  logic [1:0]   a_we;
  logic         b_wreq, b_busy, b_done, b_err;
  logic [19:0]  b_raddr;
  logic [127:0] b_rdata;
  logic [9:0]   b_waddr;
  logic [63:0]  b_wdata;
  logic [1:0]   b_we;
  int           errors = 0;
  int           checks = 0;
  int           cyc, dn;
  always #5 clk = ~clk;
  ibex_register_file_mp #(
    .RV32E(1'b0), .DataWidth(32), .NumRead(2), .NumWrite(2),
    .WriteBypass(1'b1), .DummyInstructions(1'b1), .WordZeroVal(32'h0)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en),
    .dummy_instr_id_i(a_did), .dummy_instr_wb_i(a_dwb),
    .raddr_i(a_raddr), .rdata_o(a_rdata), .waddr_i(a_waddr), .wdata_i(a_wdata), .we_i(a_we),
    .wipe_req_i(a_wreq), .wipe_busy_o(a_busy), .wipe_done_o(a_done), .err_o(a_err)
  );
  ibex_register_file_mp #(
    .RV32E(1'b1), .DataWidth(32), .NumRead(4), .NumWrite(2),
    .WriteBypass(1'b0), .DummyInstructions(1'b0), .WordZeroVal(32'h0)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en),
    .dummy_instr_id_i(1'b0), .dummy_instr_wb_i(1'b0),
    .raddr_i(b_raddr), .rdata_o(b_rdata), .waddr_i(b_waddr), .wdata_i(b_wdata), .we_i(b_we),
    .wipe_req_i(b_wreq), .wipe_busy_o(b_busy), .wipe_done_o(b_done), .err_o(b_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0; test_en = 1'b0;
    a_did = 0; a_dwb = 0; a_wreq = 0; a_raddr = '0; a_waddr = '0; a_wdata = '0; a_we = '0;
    b_wreq = 0; b_raddr = '0; b_waddr = '0; b_wdata = '0; b_we = '0;
    #3;
    chk("reset_busy", 32'(a_busy), 0);
    chk("reset_done", 32'(a_done), 0);
    chk("reset_err", 32'(a_err), 0);
    chk("reset_b_busy", 32'(b_busy), 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    // two ports to x5: port 1 wins, collision flagged
    @(negedge clk);
    a_we = 2'b11; a_waddr = {5'd5, 5'd5}; a_wdata = {32'hBBBB, 32'hAAAA}; a_raddr = {5'd0, 5'd5};
    #1 chk("collision_err", 32'(a_err), 1);
    chk("collision_bypass", a_rdata[31:0], 32'hBBBB);
    @(negedge clk); a_we = 2'b00;
    #1 chk("collision_winner", a_rdata[31:0], 32'hBBBB);
    chk("err_clear", 32'(a_err), 0);
    // same-cycle read of x7: bypassed on A, old value on B
    @(negedge clk);
    a_we = 2'b01; a_waddr = {5'd0, 5'd7}; a_wdata = {32'h0, 32'h1234}; a_raddr = {5'd7, 5'd5};
    b_we = 2'b01; b_waddr = {5'd0, 5'd7}; b_wdata = {32'h0, 32'h1234}; b_raddr = {15'd0, 5'd7};
    #1 chk("bypass_a", a_rdata[63:32], 32'h1234);
    chk("nobypass_b_old", b_rdata[31:0], 32'h0);
    @(negedge clk); a_we = 2'b00; b_we = 2'b00;
    #1 chk("write_a_next", a_rdata[63:32], 32'h1234);
    chk("write_b_next", b_rdata[31:0], 32'h1234);
    // x0 writes are discarded and never bypassed; shadow only from port 0 with dummy wb
    @(negedge clk);
    a_we = 2'b10; a_waddr = {5'd0, 5'd0}; a_wdata = {32'hFFFF, 32'h0}; a_raddr = {5'd0, 5'd0}; a_did = 1;
    #1 chk("x0_no_bypass", a_rdata[31:0], 32'h0);
    @(negedge clk); a_we = 2'b00; a_did = 0;
    #1 chk("x0_discard", a_rdata[31:0], 32'h0);
    a_did = 1;
    #1 chk("shadow_not_port1", a_rdata[31:0], 32'h0);
    @(negedge clk);
    a_did = 0; a_we = 2'b01; a_waddr = {5'd0, 5'd0}; a_wdata = {32'h0, 32'h55}; a_dwb = 1;
    @(negedge clk); a_we = 2'b00; a_dwb = 0; a_did = 1;
    #1 chk("shadow_dummy_id", a_rdata[31:0], 32'h55);
    a_did = 0;
    #1 chk("shadow_hidden", a_rdata[31:0], 32'h0);
    // fill x1..x31 then wipe, with a dropped write in the middle
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      a_we = 2'b01; a_waddr = {5'd0, 5'(i)}; a_wdata = {32'h0, 32'h1000_0000 + 32'(i)};
    end
    @(negedge clk); a_we = 2'b00; a_raddr = {5'd31, 5'd1};
    #1 chk("fill_x1", a_rdata[31:0], 32'h1000_0001);
    chk("fill_x31", a_rdata[63:32], 32'h1000_001F);
    a_wreq = 1;
    cyc = 0; dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); a_wreq = 0; a_we = 2'b00;
      if (a_busy) cyc++;
      if (a_done) dn++;
      if (a_busy && cyc == 5) begin
        a_we = 2'b01; a_waddr = {5'd0, 5'd1}; a_wdata = {32'h0, 32'hDEAD};
        #1 chk("err_write_in_wipe", 32'(a_err), 1);
      end
    end
    chk("wipe_busy_cycles", 32'(cyc), 32);
    chk("wipe_done_pulses", 32'(dn), 1);
    a_did = 1; a_raddr = {5'd31, 5'd0};
    #1 chk("wiped_shadow", a_rdata[31:0], 32'h0);
    chk("wiped_x31", a_rdata[63:32], 32'h0);
    a_did = 0; a_raddr = {5'd17, 5'd1};
    #1 chk("wiped_x1_dropped", a_rdata[31:0], 32'h0);
    chk("wiped_x17", a_rdata[63:32], 32'h0);
    // reset aborts a wipe in progress
    @(negedge clk); a_we = 2'b01; a_waddr = {5'd0, 5'd5}; a_wdata = {32'h0, 32'h5}; a_raddr = {5'd5, 5'd5};
    @(negedge clk); a_we = 2'b00; a_wreq = 1;
    #1 chk("pre_abort_x5", a_rdata[31:0], 32'h5);
    @(negedge clk); a_wreq = 0;
    repeat (9) @(negedge clk);
    chk("busy_before_reset", 32'(a_busy), 1);
    #2 rst_n = 1'b0;
    #1 chk("abort_busy", 32'(a_busy), 0);
    chk("abort_done", 32'(a_done), 0);
    chk("abort_err", 32'(a_err), 0);
    chk("abort_x5", a_rdata[31:0], 32'h0);
    @(negedge clk); rst_n = 1'b1;
    dn = 0;
    repeat (5) begin
      @(negedge clk);
      if (a_done) dn++;
    end
    chk("abort_no_done", 32'(dn), 0);
    a_wreq = 1;
    cyc = 0; dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); a_wreq = 0;
      if (a_busy) cyc++;
      if (a_done) dn++;
    end
    chk("rewipe_busy_cycles", 32'(cyc), 32);
    chk("rewipe_done_pulses", 32'(dn), 1);
    // RV32E: bit 4 aliasing, four read ports, 16-cycle wipe
    @(negedge clk); b_we = 2'b11; b_waddr = {5'd15, 5'd3}; b_wdata = {32'hF5, 32'h33};
    @(negedge clk);
    b_we = 2'b01; b_waddr = {5'd0, 5'd16}; b_wdata = {32'h0, 32'h99};
    b_raddr = {5'd0, 5'd19, 5'd15, 5'd3};
    #1 chk("e_x3", b_rdata[31:0], 32'h33);
    chk("e_x15", b_rdata[63:32], 32'hF5);
    chk("e_x19_alias", b_rdata[95:64], 32'h33);
    chk("e_x0", b_rdata[127:96], 32'h0);
    @(negedge clk); b_we = 2'b00; b_raddr = {5'd16, 5'd19, 5'd15, 5'd0};
    #1 chk("e_x16_discard", b_rdata[127:96], 32'h0);
    chk("e_x0_after", b_rdata[31:0], 32'h0);
    @(negedge clk); b_we = 2'b11; b_waddr = {5'd19, 5'd3}; b_wdata = {32'h77, 32'h66};
    #1 chk("e_alias_collision", 32'(b_err), 1);
    @(negedge clk); b_we = 2'b00; b_raddr = {15'd0, 5'd3};
    #1 chk("e_alias_winner", b_rdata[31:0], 32'h77);
    b_wreq = 1;
    cyc = 0; dn = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk); b_wreq = 0;
      if (b_busy) cyc++;
      if (b_done) dn++;
    end
    chk("e_wipe_cycles", 32'(cyc), 16);
    chk("e_wipe_done", 32'(dn), 1);
    b_raddr = {5'd0, 5'd19, 5'd15, 5'd3};
    #1 chk("e_wiped_x3", b_rdata[31:0], 32'h0);
    chk("e_wiped_x15", b_rdata[63:32], 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
